craps_game_fsm: RTL and testbench
=================================

Name: craps_game_fsm

Overview:
- Parametrised successor to the two-dice game controller.
- Captures two die values on rising edges of the roll buttons, applies come-out and point rules, and holds the Win/Lose result until a new game starts.
- Adds parametric die size, a bounded point phase with a visible rolls-left count, button edge detection, input clamping and a `new_game` restart.
- Sits between the free-running die counters and the seven-segment display driver.

Parameters:
- DIE_FACES, 6, faces per die; legal range 2..15.
- MAX_POINT_ROLLS, 4, point-phase rolls allowed before forced loss; 0 = unlimited; legal range 0..15.
- STAT_W, 8, width of the win/loss tally counters (used only with the optional feature).

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- Rb1  in  1  roll button for die 1, level input.
- Rb2  in  1  roll button for die 2, level input.
- new_game  in  1  one-cycle request to leave WIN/LOSE.
- cntr1  in  4  die-1 counter value.
- cntr2  in  4  die-2 counter value.
- Win  out  1  game won.
- Lose  out  1  game lost.
- Roll  out  1  game in progress; more rolls expected.
- DiceOut1  out  4  last captured die-1 value.
- DiceOut2  out  4  last captured die-2 value.
- point  out  5  established point; 0 = come-out phase.
- rolls_left  out  4  remaining point-phase rolls; 0 when unlimited or when not in point phase.
- win_count  out  STAT_W  games won (STATS_EN only).
- loss_count  out  STAT_W  games lost (STATS_EN only).

Behaviour:
- Reset (synchronous, active-high, on CLK posedge):
  - State = IDLE; Win = 0, Lose = 0, Roll = 1.
  - DiceOut1 = 0, DiceOut2 = 0, point = 0, rolls_left = 0.
  - Edge-detect history registers = 0.
  - Reset has priority over every other input in every state, including mid-point-phase.
- Edge detection: a rise is the button sampled 1 this edge and 0 the previous edge. A held button yields exactly one rise.
- Die capture and clamping: the captured value is the die input sampled at the rise edge. Value 0 becomes 1; a value greater than DIE_FACES becomes DIE_FACES.
- All outputs are registered.
- States and transitions:
  - IDLE: on Rb1 rise, capture DiceOut1 and go to DIE1. A simultaneous Rb2 rise is ignored.
  - DIE1: on Rb2 rise, capture DiceOut2 and go to EVAL. Rb1 rises are ignored.
  - EVAL: one cycle. sum = DiceOut1 + DiceOut2, 5-bit, no overflow.
    - Come-out (point == 0):
      - sum 7 or 11 -> WIN.
      - sum 2, 3 or 12 -> LOSE.
      - otherwise: point = sum; rolls_left = MAX_POINT_ROLLS; go to IDLE.
    - Point phase (point != 0), priority in this order:
      - sum == point -> WIN.
      - sum == 7 -> LOSE.
      - MAX_POINT_ROLLS != 0 and rolls_left == 1 -> LOSE with rolls_left = 0.
      - otherwise: decrement rolls_left (when bounded); go to IDLE.
  - WIN / LOSE:
    - On entry: Win or Lose = 1, Roll = 0.
    - Roll buttons are ignored.
    - new_game -> IDLE with Win = 0, Lose = 0, Roll = 1, point = 0, rolls_left = 0. DiceOut1/DiceOut2 are kept.
    - new_game has no effect in any other state.
- Latency: Rb2 rise sampled at edge N -> EVAL during cycle N..N+1 -> Win/Lose/point/rolls_left valid after edge N+1.
- Win and Lose are never both 1.

Optional Feature:
- Macro: CRAPS_STATS_EN.
- Defined:
  - win_count and loss_count exist and reset to 0 on reset.
  - Each increments on the edge that enters WIN or LOSE respectively.
  - Both saturate at 2^STAT_W - 1.
  - new_game does not clear them.
- Undefined: both ports and their registers are absent; all other behaviour is unchanged.

Decomposition:
- Shared package craps_pkg:
  - State encoding constants: IDLE, DIE1, EVAL, WIN, LOSE.
  - Come-out constants: WIN_SUM_A = 7, WIN_SUM_B = 11, LOSE_SUM_A = 2, LOSE_SUM_B = 3, LOSE_SUM_C = 12, SEVEN_OUT = 7.
  - Sum width constant = 5.
- Sub-module rise_detect (one register plus AND-NOT), instantiated once per button.
- Clamping and rule evaluation stay inline.

Test Plan:
1. Reset; cntr1 = 3, cntr2 = 4; Rb1 rise, then Rb2 rise -> after 2 edges: Win = 1, Lose = 0, Roll = 0, DiceOut1 = 3, DiceOut2 = 4, point = 0.
2. Reset; dice 1 + 1 -> Lose = 1, Roll = 0. Then new_game pulse -> Lose = 0, Roll = 1, point = 0.
3. Dice 2 + 2 -> point = 4, rolls_left = 4, Roll = 1. Then 1 + 3 -> Win = 1. Separately, point 4 then 3 + 4 -> Lose = 1 (seven-out beats count).
4. Point 4, then rolls 2+3, 1+5, 2+4, 5+5 -> rolls_left 3, 2, 1, then Lose = 1 with rolls_left = 0. With MAX_POINT_ROLLS = 0, ten non-7, non-point rolls -> still Roll = 1.
5. Boundary cases:
   - Rb1 held high 5 cycles -> single capture.
   - Rb1 and Rb2 rise together in IDLE -> only DiceOut1 captured.
   - cntr1 = 0, cntr2 = 9 -> captured as 1 and 6.
   - reset during point phase -> all outputs at reset values after that edge.
6. CRAPS_STATS_EN: win, new_game, loss -> win_count = 1, loss_count = 1. new_game while in IDLE -> no effect. STAT_W = 2 with 5 wins -> win_count = 3.

Source files
------------

// File: rtl/craps_pkg.sv
// craps_pkg: shared constants for the two-dice game controller.
//   State encodings (kept as plain constants so legacy code that compares
//   raw state values still works), come-out/point sums and the sum width.
package craps_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE = 3'd0;
    localparam logic [STATE_W-1:0] DIE1 = 3'd1;
    localparam logic [STATE_W-1:0] EVAL = 3'd2;
    localparam logic [STATE_W-1:0] WIN  = 3'd3;
    localparam logic [STATE_W-1:0] LOSE = 3'd4;

    localparam int unsigned SUM_W = 5;

    localparam logic [SUM_W-1:0] WIN_SUM_A  = 5'd7;
    localparam logic [SUM_W-1:0] WIN_SUM_B  = 5'd11;
    localparam logic [SUM_W-1:0] LOSE_SUM_A = 5'd2;
    localparam logic [SUM_W-1:0] LOSE_SUM_B = 5'd3;
    localparam logic [SUM_W-1:0] LOSE_SUM_C = 5'd12;
    localparam logic [SUM_W-1:0] SEVEN_OUT  = 5'd7;

endpackage

// File: rtl/rise_detect.sv
// rise_detect: single-cycle rising-edge detector for a level button input.
//   CLK   - system clock
//   reset - synchronous active-high reset, clears the history register
//   btn   - level input
//   rise  - high while btn is 1 now and was 0 at the previous edge
module rise_detect (
    input  logic CLK,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic prev;

    always_ff @(posedge CLK) begin
        if (reset) prev <= 1'b0;
        else       prev <= btn;
    end

    assign rise = btn & ~prev;

endmodule

// File: rtl/craps_game_fsm.sv
// craps_game_fsm: two-dice game controller with a bounded point phase.
//   Captures die 1 on an Rb1 rise and die 2 on an Rb2 rise, evaluates the
//   sum for one cycle, and holds Win/Lose until new_game.
// Ports:
//   CLK, reset          - clock, synchronous active-high reset
//   Rb1, Rb2            - roll buttons (level, edge-detected internally)
//   new_game            - leaves WIN/LOSE, ignored elsewhere
//   cntr1, cntr2        - free-running die counters, clamped to 1..DIE_FACES
//   Win, Lose, Roll     - game status (registered)
//   DiceOut1, DiceOut2  - last captured dice
//   point, rolls_left   - established point and remaining point-phase rolls
//   win_count, loss_count - saturating tallies, present only with CRAPS_STATS_EN
// Optional feature macro: CRAPS_STATS_EN
module craps_game_fsm
    import craps_pkg::*;
#(
    parameter int unsigned DIE_FACES       = 6,
    parameter int unsigned MAX_POINT_ROLLS = 4
`ifdef CRAPS_STATS_EN
    ,
    parameter int unsigned STAT_W          = 8
`endif
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             Rb1,
    input  logic             Rb2,
    input  logic             new_game,
    input  logic [3:0]       cntr1,
    input  logic [3:0]       cntr2,
    output logic             Win,
    output logic             Lose,
    output logic             Roll,
    output logic [3:0]       DiceOut1,
    output logic [3:0]       DiceOut2,
    output logic [4:0]       point,
    output logic [3:0]       rolls_left
`ifdef CRAPS_STATS_EN
    ,
    output logic [STAT_W-1:0] win_count,
    output logic [STAT_W-1:0] loss_count
`endif
);

    localparam logic [3:0] FACES   = 4'(DIE_FACES);
    localparam logic [3:0] MAXR    = 4'(MAX_POINT_ROLLS);
    localparam logic       BOUNDED = (MAX_POINT_ROLLS != 0);

    logic [STATE_W-1:0] state;
    logic               rise1, rise2;
    logic [3:0]         clamp1, clamp2;
    logic [SUM_W-1:0]   sum;
    logic               eval_win, eval_lose, eval_forced;

    rise_detect u_rise1 (.CLK(CLK), .reset(reset), .btn(Rb1), .rise(rise1));
    rise_detect u_rise2 (.CLK(CLK), .reset(reset), .btn(Rb2), .rise(rise2));

    always_comb begin
        clamp1 = cntr1;
        if (cntr1 == 4'd0)       clamp1 = 4'd1;
        else if (cntr1 > FACES)  clamp1 = FACES;
        clamp2 = cntr2;
        if (cntr2 == 4'd0)       clamp2 = 4'd1;
        else if (cntr2 > FACES)  clamp2 = FACES;
    end

    assign sum = {1'b0, DiceOut1} + {1'b0, DiceOut2};

    // Outcome of the sum currently held in DiceOut1/DiceOut2; only acted on in EVAL.
    always_comb begin
        eval_win    = 1'b0;
        eval_lose   = 1'b0;
        eval_forced = 1'b0;
        if (point == '0) begin
            if (sum == WIN_SUM_A || sum == WIN_SUM_B)
                eval_win = 1'b1;
            else if (sum == LOSE_SUM_A || sum == LOSE_SUM_B || sum == LOSE_SUM_C)
                eval_lose = 1'b1;
        end else begin
            if (sum == point)
                eval_win = 1'b1;
            else if (sum == SEVEN_OUT)
                eval_lose = 1'b1;
            else if (BOUNDED && rolls_left == 4'd1) begin
                eval_lose   = 1'b1;
                eval_forced = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= IDLE;
            Win        <= 1'b0;
            Lose       <= 1'b0;
            Roll       <= 1'b1;
            DiceOut1   <= '0;
            DiceOut2   <= '0;
            point      <= '0;
            rolls_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise1) begin
                        DiceOut1 <= clamp1;
                        state    <= DIE1;
                    end
                end
                DIE1: begin
                    if (rise2) begin
                        DiceOut2 <= clamp2;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    if (eval_win) begin
                        Win   <= 1'b1;
                        Roll  <= 1'b0;
                        state <= WIN;
                    end else if (eval_lose) begin
                        Lose  <= 1'b1;
                        Roll  <= 1'b0;
                        state <= LOSE;
                        if (eval_forced) rolls_left <= '0;
                    end else begin
                        state <= IDLE;
                        if (point == '0) begin
                            point      <= sum;
                            rolls_left <= MAXR;
                        end else if (BOUNDED) begin
                            rolls_left <= rolls_left - 4'd1;
                        end
                    end
                end
                WIN, LOSE: begin
                    if (new_game) begin
                        state      <= IDLE;
                        Win        <= 1'b0;
                        Lose       <= 1'b0;
                        Roll       <= 1'b1;
                        point      <= '0;
                        rolls_left <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CRAPS_STATS_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            win_count  <= '0;
            loss_count <= '0;
        end else if (state == EVAL) begin
            if (eval_win && win_count != '1)
                win_count <= win_count + 1'b1;
            else if (eval_lose && loss_count != '1)
                loss_count <= loss_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_craps_game_fsm.sv
// tb_craps_game_fsm: self-checking bench for craps_game_fsm.
//   dut0: default parameters; dut1: unlimited point phase.
//   With CRAPS_STATS_EN, dut2 uses STAT_W = 2 to exercise saturation.
module tb_craps_game_fsm;

    logic       CLK = 1'b0;
    logic       reset = 1'b1, Rb1 = 1'b0, Rb2 = 1'b0, new_game = 1'b0;
    logic [3:0] cntr1 = '0, cntr2 = '0;

    logic       w0, l0, r0, w1, l1, r1;
    logic [3:0] do1_0, do2_0, rl0, do1_1, do2_1, rl1;
    logic [4:0] pt0, pt1;
`ifdef CRAPS_STATS_EN
    logic [7:0] wc0, lc0;
    logic [1:0] wc2, lc2;
    logic       w2, l2, r2;
    logic [3:0] do1_2, do2_2, rl2;
    logic [4:0] pt2;
`endif

    always #5 CLK = ~CLK;

    craps_game_fsm #(.DIE_FACES(6), .MAX_POINT_ROLLS(4)) dut0 (
        .CLK(CLK), .reset(reset), .Rb1(Rb1), .Rb2(Rb2), .new_game(new_game),
        .cntr1(cntr1), .cntr2(cntr2), .Win(w0), .Lose(l0), .Roll(r0),
        .DiceOut1(do1_0), .DiceOut2(do2_0), .point(pt0), .rolls_left(rl0)
`ifdef CRAPS_STATS_EN
        , .win_count(wc0), .loss_count(lc0)
`endif
    );

    craps_game_fsm #(.DIE_FACES(6), .MAX_POINT_ROLLS(0)) dut1 (
        .CLK(CLK), .reset(reset), .Rb1(Rb1), .Rb2(Rb2), .new_game(new_game),
        .cntr1(cntr1), .cntr2(cntr2), .Win(w1), .Lose(l1), .Roll(r1),
        .DiceOut1(do1_1), .DiceOut2(do2_1), .point(pt1), .rolls_left(rl1)
`ifdef CRAPS_STATS_EN
        , .win_count(), .loss_count()
`endif
    );

`ifdef CRAPS_STATS_EN
    craps_game_fsm #(.DIE_FACES(6), .MAX_POINT_ROLLS(4), .STAT_W(2)) dut2 (
        .CLK(CLK), .reset(reset), .Rb1(Rb1), .Rb2(Rb2), .new_game(new_game),
        .cntr1(cntr1), .cntr2(cntr2), .Win(w2), .Lose(l2), .Roll(r2),
        .DiceOut1(do1_2), .DiceOut2(do2_2), .point(pt2), .rolls_left(rl2),
        .win_count(wc2), .loss_count(lc2)
    );
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: one game record per DUT.
    // m_stage: 0 waiting for die 1, 1 waiting for die 2, 2 sum pending.
    // m_res:   0 playing, 1 won, 2 lost.
    int m_max[2];
    int m_stage[2], m_res[2], m_point[2], m_rl[2], m_d1[2], m_d2[2];
    int m_wins[2], m_losses[2];
    bit pb1 = 1'b0, pb2 = 1'b0;

    function automatic int clampv(input int v);
        if (v == 0) return 1;
        if (v > 6) return 6;
        return v;
    endfunction

    task automatic model_score(input int i);
        int s;
        s = m_d1[i] + m_d2[i];
        m_stage[i] = 0;
        if (m_point[i] == 0) begin
            if (s == 7 || s == 11) m_res[i] = 1;
            else if (s == 2 || s == 3 || s == 12) m_res[i] = 2;
            else begin
                m_point[i] = s;
                m_rl[i] = m_max[i];
            end
        end else if (s == m_point[i]) m_res[i] = 1;
        else if (s == 7) m_res[i] = 2;
        else if (m_max[i] != 0) begin
            m_rl[i] = m_rl[i] - 1;
            if (m_rl[i] == 0) m_res[i] = 2;
        end
        if (m_res[i] == 1) m_wins[i]++;
        if (m_res[i] == 2) m_losses[i]++;
    endtask

    task automatic model_edge(input bit rst, input bit ng, input bit rise1, input bit rise2,
                              input int a, input int b);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_stage[i] = 0; m_res[i] = 0; m_point[i] = 0; m_rl[i] = 0;
                m_d1[i] = 0; m_d2[i] = 0; m_wins[i] = 0; m_losses[i] = 0;
            end else if (m_res[i] != 0) begin
                if (ng) begin
                    m_res[i] = 0; m_point[i] = 0; m_rl[i] = 0;
                end
            end else if (m_stage[i] == 0) begin
                if (rise1) begin
                    m_d1[i] = clampv(a);
                    m_stage[i] = 1;
                end
            end else if (m_stage[i] == 1) begin
                if (rise2) begin
                    m_d2[i] = clampv(b);
                    m_stage[i] = 2;
                end
            end else begin
                model_score(i);
            end
        end
    endtask

    // {Win, Lose, Roll, DiceOut1, DiceOut2, point, rolls_left}; rolls_left is
    // only compared while a game is in progress.
    function automatic logic [19:0] exp_vec(input int i);
        return {m_res[i] == 1, m_res[i] == 2, m_res[i] == 0, 4'(m_d1[i]), 4'(m_d2[i]),
                5'(m_point[i]), (m_res[i] != 0) ? 4'd0 : 4'(m_rl[i])};
    endfunction

    function automatic logic [19:0] obs_vec(input int i);
        if (i == 0) return {w0, l0, r0, do1_0, do2_0, pt0, (m_res[0] != 0) ? 4'd0 : rl0};
        return {w1, l1, r1, do1_1, do2_1, pt1, (m_res[1] != 0) ? 4'd0 : rl1};
    endfunction

    task automatic step(input bit b1, input bit b2, input bit ng, input bit rst,
                        input int a, input int b);
        bit e1, e2;
        Rb1 = b1; Rb2 = b2; new_game = ng; reset = rst;
        cntr1 = 4'(a); cntr2 = 4'(b);
        e1 = b1 && !pb1;
        e2 = b2 && !pb2;
        pb1 = rst ? 1'b0 : b1;
        pb2 = rst ? 1'b0 : b2;
        @(posedge CLK);
        model_edge(rst, ng, e1, e2, a, b);
        #1;
    endtask

    task automatic roll(input int a, input int b);
        step(1, 0, 0, 0, a, 0);
        step(0, 1, 0, 0, a, b);
        step(0, 0, 0, 0, a, b);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic pulse_new_game();
        step(0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 5, 2);
        step(0, 1, 0, 0, 5, 2);
        do_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== 20'h20000) begin
                failures++;
                $display("FAIL reset dut%0d got=%h exp=%h", i, obs_vec(i), 20'h20000);
            end
        end
    endtask

    task automatic test_comeout();
        do_reset();
        roll(3, 4);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
                failures++;
                $display("FAIL comeout_win dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
            end
        end
        checks++;
        if ({w0, l0, r0, do1_0, do2_0, pt0} !== {3'b100, 4'd3, 4'd4, 5'd0}) begin
            failures++;
            $display("FAIL comeout_win_direct got=%b%b%b %0d %0d %0d", w0, l0, r0, do1_0, do2_0, pt0);
        end
        do_reset();
        roll(1, 1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
                failures++;
                $display("FAIL comeout_lose dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
            end
        end
        pulse_new_game();
        checks++;
        if ({w0, l0, r0, pt0, rl0, do1_0, do2_0} !== {3'b001, 5'd0, 4'd0, 4'd1, 4'd1}) begin
            failures++;
            $display("FAIL new_game got=%b%b%b pt=%0d rl=%0d d=%0d,%0d exp=001 pt=0 rl=0 d=1,1",
                     w0, l0, r0, pt0, rl0, do1_0, do2_0);
        end
    endtask

    task automatic test_point();
        do_reset();
        roll(2, 2);
        checks++;
        if ({r0, pt0, rl0, rl1} !== {1'b1, 5'd4, 4'd4, 4'd0}) begin
            failures++;
            $display("FAIL point_set got roll=%b pt=%0d rl0=%0d rl1=%0d exp 1 4 4 0", r0, pt0, rl0, rl1);
        end
        roll(1, 3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
                failures++;
                $display("FAIL point_win dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
            end
        end
        do_reset();
        roll(2, 2);
        roll(3, 4);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== exp_vec(i) || !(i == 0 ? l0 : l1)) begin
                failures++;
                $display("FAIL seven_out dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_roll_limit();
        int da[10] = '{2, 1, 2, 5, 4, 4, 5, 6, 1, 3};
        int db[10] = '{3, 5, 4, 5, 5, 6, 6, 6, 2, 5};
        do_reset();
        roll(2, 2);
        for (int k = 0; k < 10; k++) begin
            roll(da[k], db[k]);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL roll_limit_%0d dut%0d got=%h exp=%h", k, i, obs_vec(i), exp_vec(i));
                end
            end
            if (k == 3) begin
                checks++;
                if ({l0, w0, rl0} !== {1'b1, 1'b0, 4'd0}) begin
                    failures++;
                    $display("FAIL forced_loss got lose=%b win=%b rl=%0d exp 1 0 0", l0, w0, rl0);
                end
            end
        end
        checks++;
        if ({r1, w1, l1, pt1, rl1} !== {3'b100, 5'd4, 4'd0}) begin
            failures++;
            $display("FAIL unlimited got roll=%b win=%b lose=%b pt=%0d rl=%0d exp 1 0 0 4 0",
                     r1, w1, l1, pt1, rl1);
        end
    endtask

    task automatic test_boundaries();
        do_reset();
        step(1, 0, 0, 0, 2, 0);
        step(1, 1, 0, 0, 5, 3);
        step(1, 0, 0, 0, 5, 3);
        step(1, 0, 0, 0, 6, 3);
        step(1, 0, 0, 0, 6, 3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== exp_vec(i) || (i == 0 ? do1_0 : do1_1) !== 4'd2) begin
                failures++;
                $display("FAIL held_button dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
            end
        end
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 4, 5);
        step(0, 0, 0, 0, 4, 5);
        checks++;
        if ({do1_0, do2_0} !== {4'd4, 4'd3}) begin
            failures++;
            $display("FAIL simultaneous got d=%0d,%0d exp=4,3", do1_0, do2_0);
        end
        step(0, 1, 0, 0, 4, 6);
        step(0, 0, 0, 0, 4, 6);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
                failures++;
                $display("FAIL simultaneous_eval dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i));
            end
        end
        do_reset();
        roll(0, 9);
        checks++;
        if ({do1_0, do2_0, w0} !== {4'd1, 4'd6, 1'b1}) begin
            failures++;
            $display("FAIL clamp got d=%0d,%0d win=%b exp=1,6 win=1", do1_0, do2_0, w0);
        end
        do_reset();
        roll(2, 3);
        roll(1, 2);
        do_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_vec(i) !== 20'h20000 || (i == 0 ? rl0 : rl1) !== 4'd0) begin
                failures++;
                $display("FAIL reset_mid_point dut%0d got=%h exp=%h", i, obs_vec(i), 20'h20000);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 60; k++) begin
            if (m_res[0] != 0 && m_res[1] != 0 || $urandom_range(0, 5) == 0)
                pulse_new_game();
            else
                roll($urandom_range(0, 15), $urandom_range(0, 15));
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL random_%0d dut%0d got=%h exp=%h", k, i, obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

`ifdef CRAPS_STATS_EN
    task automatic test_stats();
        int ew;
        do_reset();
        checks++;
        if ({wc0, lc0} !== 16'h0) begin
            failures++;
            $display("FAIL stats_reset got w=%0d l=%0d exp=0 0", wc0, lc0);
        end
        roll(3, 4);
        pulse_new_game();
        roll(1, 1);
        pulse_new_game();
        pulse_new_game();
        checks++;
        if ({wc0, lc0} !== {8'd1, 8'd1} || {r0, w0, l0} !== 3'b100) begin
            failures++;
            $display("FAIL stats_win_loss got w=%0d l=%0d roll=%b exp=1 1 1", wc0, lc0, r0);
        end
        for (int k = 0; k < 5; k++) begin
            roll(5, 6);
            pulse_new_game();
        end
        ew = (m_wins[0] > 3) ? 3 : m_wins[0];
        checks++;
        if (wc2 !== 2'(ew) || wc0 !== 8'(m_wins[0]) || lc2 !== 2'(m_losses[0])) begin
            failures++;
            $display("FAIL stats_saturate got w2=%0d w0=%0d l2=%0d exp=%0d %0d %0d",
                     wc2, wc0, lc2, ew, m_wins[0], m_losses[0]);
        end
    endtask
`endif

    initial begin
        m_max[0] = 4;
        m_max[1] = 0;
        test_reset();
        test_comeout();
        test_point();
        test_roll_limit();
        test_boundaries();
        test_random();
`ifdef CRAPS_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
